// File: rtl/answer_countdown_pkg.sv
// Shared types and helpers for the quiz round timer: FSM states, BCD digits,
// and the BCD countdown arithmetic.
package answer_countdown_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRAB,
    ANSWER,
    DONE
  } state_t;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t tens;
    bcd_t ones;
  } bcd_pair_t;

  // Decrement a two-digit BCD value, saturating at 00.
  function automatic bcd_pair_t bcd_dec(input bcd_pair_t d);
    bcd_pair_t r;
    r = d;
    if (d.ones != 4'd0) begin
      r.ones = d.ones - 4'd1;
    end else if (d.tens != 4'd0) begin
      r.tens = d.tens - 4'd1;
      r.ones = 4'd9;
    end
    return r;
  endfunction

  function automatic bcd_pair_t to_bcd(input int unsigned v);
    bcd_pair_t r;
    r.tens = 4'(v / 10);
    r.ones = 4'(v % 10);
    return r;
  endfunction

endpackage

// File: rtl/answer_countdown_if.sv
// Round control and display signals between the host/selector side and the
// round timer.
interface answer_countdown_if;
  import answer_countdown_pkg::*;

  logic Start;
  logic Timer_Start;
  logic TimeOver_Block;
  logic Time_Up;
  logic Buzzer_Timeout;
  bcd_t Sec_Tens;
  bcd_t Sec_Ones;

  modport master (
    output Start, Timer_Start,
    input  TimeOver_Block, Time_Up, Buzzer_Timeout, Sec_Tens, Sec_Ones
  );

  modport slave (
    input  Start, Timer_Start,
    output TimeOver_Block, Time_Up, Buzzer_Timeout, Sec_Tens, Sec_Ones
  );
endinterface

// File: rtl/answer_countdown_tick_gen.sv
// One-second prescaler: counts 0..TICK_DIV-1 and flags the last count.
module tick_gen #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic clr,
  output logic tick
);
  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cnt <= '0;
    end else if (clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);
endmodule

// File: rtl/answer_countdown.sv
// Round timer: grab window, answer window, expiry flags, timeout buzzer and
// two-digit BCD seconds display.
module answer_countdown
  import answer_countdown_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 50_000_000,
  parameter int unsigned GRAB_SEC    = 20,
  parameter int unsigned ANSWER_SEC  = 30,
  parameter int unsigned BUZZ_CYCLES = 25_000_000
) (
  input  logic                CLK,
  input  logic                RSTn,
  answer_countdown_if.slave   bus
);
  localparam int unsigned BW = $clog2(BUZZ_CYCLES + 1);
  localparam logic [BW-1:0] BUZZ_LOAD = BW'(BUZZ_CYCLES);
  localparam bcd_pair_t GRAB_BCD   = to_bcd(GRAB_SEC);
  localparam bcd_pair_t ANSWER_BCD = to_bcd(ANSWER_SEC);
  localparam bcd_pair_t ONE_BCD    = '{tens: 4'd0, ones: 4'd1};

  state_t        state_q, state_d;
  bcd_pair_t     dig_q, dig_d;
  logic          tob_q, tob_d;
  logic          tu_q, tu_d;
  logic          buzz_q, buzz_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          tick;
  logic          pre_clr;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .CLK  (CLK),
    .RSTn (RSTn),
    .clr  (pre_clr),
    .tick (tick)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
      dig_q   <= '0;
      tob_q   <= 1'b0;
      tu_q    <= 1'b0;
      buzz_q  <= 1'b0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      dig_q   <= dig_d;
      tob_q   <= tob_d;
      tu_q    <= tu_d;
      buzz_q  <= buzz_d;
      bcnt_q  <= bcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dig_d   = dig_q;
    tob_d   = tob_q;
    tu_d    = tu_q;
    buzz_d  = buzz_q;
    bcnt_d  = bcnt_q;

    if (bus.Start) begin
      state_d = IDLE;
      dig_d   = '0;
      tob_d   = 1'b0;
      tu_d    = 1'b0;
      buzz_d  = 1'b0;
      bcnt_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.Timer_Start) begin
            state_d = ANSWER;
            dig_d   = ANSWER_BCD;
          end else begin
            state_d = GRAB;
            dig_d   = GRAB_BCD;
          end
        end
        GRAB: begin
          // A lock arriving on the final tick still takes precedence over expiry.
          if (bus.Timer_Start) begin
            state_d = ANSWER;
            dig_d   = ANSWER_BCD;
          end else if (tick) begin
            dig_d = bcd_dec(dig_q);
            if (dig_q == ONE_BCD) begin
              state_d = DONE;
              tob_d   = 1'b1;
              buzz_d  = 1'b1;
              bcnt_d  = BUZZ_LOAD;
            end
          end
        end
        ANSWER: begin
          if (tick) begin
            dig_d = bcd_dec(dig_q);
            if (dig_q == ONE_BCD) begin
              state_d = DONE;
              tu_d    = 1'b1;
              buzz_d  = 1'b1;
              bcnt_d  = BUZZ_LOAD;
            end
          end
        end
        DONE: begin
          if (bcnt_q > BW'(1)) begin
            bcnt_d = bcnt_q - BW'(1);
          end else begin
            bcnt_d = '0;
            buzz_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Prescaler restarts on every state entry and is held clear while idle.
  assign pre_clr = bus.Start || (state_q == IDLE) || (state_d != state_q);

  assign bus.TimeOver_Block = tob_q;
  assign bus.Time_Up        = tu_q;
  assign bus.Buzzer_Timeout = buzz_q;
  assign bus.Sec_Tens       = dig_q.tens;
  assign bus.Sec_Ones       = dig_q.ones;
endmodule

// File: tb/tb_answer_countdown.sv
// Directed bench for answer_countdown with a small tick divider and short windows.
module tb_answer_countdown;
  logic CLK;
  logic RSTn;
  int   checks;
  int   errors;

  answer_countdown_if bus();

  answer_countdown #(
    .TICK_DIV    (4),
    .GRAB_SEC    (3),
    .ANSWER_SEC  (12),
    .BUZZ_CYCLES (6)
  ) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        start;
    logic        ts;
    int unsigned reps;
    logic [3:0]  tens;
    logic [3:0]  ones;
    logic        tob;
    logic        tu;
    logic        buzz;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic start, input logic ts, input int unsigned reps,
                              input logic [3:0] tens, input logic [3:0] ones,
                              input logic tob, input logic tu, input logic buzz);
    vec_t v;
    v.start = start; v.ts = ts; v.reps = reps;
    v.tens = tens; v.ones = ones; v.tob = tob; v.tu = tu; v.buzz = buzz;
    tbl.push_back(v);
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] tens, input logic [3:0] ones,
                       input logic tob, input logic tu, input logic buzz);
    logic [10:0] got;
    logic [10:0] exp;
    got = {bus.Sec_Tens, bus.Sec_Ones, bus.TimeOver_Block, bus.Time_Up, bus.Buzzer_Timeout};
    exp = {tens, ones, tob, tu, buzz};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got digits %h%h tob %b tu %b buzz %b, expected digits %h%h tob %b tu %b buzz %b",
               name, $time, got[10:7], got[6:3], got[2], got[1], got[0],
               exp[10:7], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    RSTn = 1'b1;
    bus.Start = 1'b1;
    bus.Timer_Start = 1'b0;
    #1 RSTn = 1'b0;
    #3 check("reset", 4'd0, 4'd0, 0, 0, 0);
    #8 RSTn = 1'b1;

    // grab window expires: 03 -> 02 -> 01 -> 00, buzzer 6 cycles
    add(1, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 4, 0, 3, 0, 0, 0);
    add(0, 0, 4, 0, 2, 0, 0, 0);
    add(0, 0, 4, 0, 1, 0, 0, 0);
    add(0, 0, 6, 0, 0, 1, 0, 1);
    add(0, 0, 2, 0, 0, 1, 0, 0);
    add(1, 0, 1, 0, 0, 0, 0, 0);
    // lock two cycles into grab, answer window with BCD borrow, then expiry
    add(0, 0, 2, 0, 3, 0, 0, 0);
    add(0, 1, 4, 1, 2, 0, 0, 0);
    add(0, 1, 4, 1, 1, 0, 0, 0);
    add(0, 1, 4, 1, 0, 0, 0, 0);
    add(0, 0, 4, 0, 9, 0, 0, 0);
    for (int d = 8; d >= 1; d--) add(0, 0, 4, 0, 4'(d), 0, 0, 0);
    add(0, 0, 6, 0, 0, 0, 1, 1);
    add(0, 0, 3, 0, 0, 0, 1, 0);
    add(1, 0, 1, 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      bus.Start = tbl[i].start;
      bus.Timer_Start = tbl[i].ts;
      for (int unsigned r = 0; r < tbl[i].reps; r++) begin
        step();
        check($sformatf("vec%0d.%0d", i, r), tbl[i].tens, tbl[i].ones,
              tbl[i].tob, tbl[i].tu, tbl[i].buzz);
      end
    end

    // lock coincides with the final grab tick
    bus.Start = 1'b0;
    step();
    check("tie_entry", 0, 3, 0, 0, 0);
    repeat (11) step();
    check("tie_at01", 0, 1, 0, 0, 0);
    bus.Timer_Start = 1'b1;
    step();
    check("tie_answer", 1, 2, 0, 0, 0);
    bus.Start = 1'b1;
    bus.Timer_Start = 1'b0;
    step();
    check("tie_clear", 0, 0, 0, 0, 0);

    // Start raised on the third buzzer cycle
    bus.Start = 1'b0;
    step();
    repeat (12) step();
    check("buzz_first", 0, 0, 1, 0, 1);
    repeat (2) step();
    check("buzz_third", 0, 0, 1, 0, 1);
    bus.Start = 1'b1;
    step();
    check("buzz_abort", 0, 0, 0, 0, 0);
    bus.Start = 1'b0;
    step();
    check("regrab", 0, 3, 0, 0, 0);

    // asynchronous reset in the middle of the answer window
    bus.Timer_Start = 1'b1;
    step();
    check("ans_entry", 1, 2, 0, 0, 0);
    repeat (5) step();
    check("ans_mid", 1, 1, 0, 0, 0);
    #1 RSTn = 1'b0;
    #1 check("async_rst", 0, 0, 0, 0, 0);
    bus.Timer_Start = 1'b0;
    #2 RSTn = 1'b1;
    step();
    check("post_rst_grab", 0, 3, 0, 0, 0);
    repeat (4) step();
    check("post_rst_tick", 0, 2, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
